// File: rtl/ntt_ctrl_pkg.sv
// Shared types and helpers for the NTT/INTT layer-sequencing controller.
// Optional n^-1 scaling layer is enabled by the NTT_CTRL_SCALE_EN macro.
package ntt_ctrl_pkg;

  typedef enum logic [7:0] {
    S_IDLE     = 8'b0000_0001,
    S_LOAD     = 8'b0000_0010,
    S_WAIT_CAL = 8'b0000_0100,
    S_FILL     = 8'b0000_1000,
    S_RUN      = 8'b0001_0000,
    S_DRAIN    = 8'b0010_0000,
    S_GAP      = 8'b0100_0000,
    S_OUT      = 8'b1000_0000
  } state_e;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  function automatic int layer_period(
    input int depth,
    input int pipe_fill
  );
    return (1 << (depth - 1)) + pipe_fill + 1;
  endfunction

endpackage

// File: rtl/ctrl_phase_timer.sv
// Loadable down-counter; expire is high in the last cycle of a phase.
// Holds while en is low; synchronous active-high reset.
module ctrl_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == '0);

endmodule

// File: rtl/ntt_ctrl_fsm.sv
// Layer-sequencing controller shared by forward and inverse NTT.
// Define NTT_CTRL_SCALE_EN to append the n^-1 scaling layer in INTT mode.
module ntt_ctrl_fsm
  import ntt_ctrl_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int PIPE_FILL = 5,
  parameter int LAYERS    = 7
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          set,
  input  logic                          start,
  input  logic                          mode,
  input  logic                          full_in,
  input  logic                          cal_en,
  input  logic                          full_out,
  output logic                          rd_ctrl,
  output logic                          wr_ctrl,
  output logic [1:0]                    ram_we,
  output logic                          layer_type,
  output logic [$clog2(LAYERS+2)-1:0]   layer,
  output logic [$clog2(DEPTH+1)-1:0]    len_log,
  output logic                          res_bank,
  output logic                          readin_ok,
  output logic                          busy,
  output logic                          done
);

  localparam int LYW = $clog2(LAYERS + 2);
  localparam int LNW = $clog2(DEPTH + 1);
  localparam int TW  = DEPTH - 1;
  localparam int RUN_LEN =
    layer_period(DEPTH, PIPE_FILL) - 2 * PIPE_FILL - 1;
  localparam logic [TW-1:0] FILL_LD = TW'(PIPE_FILL - 1);
  localparam logic [TW-1:0] RUN_LD  = TW'(RUN_LEN - 1);
  localparam logic LAYERS_ODD = ((LAYERS % 2) == 1);

`ifdef NTT_CTRL_SCALE_EN
  localparam logic SCALE_EN = 1'b1;
`else
  localparam logic SCALE_EN = 1'b0;
`endif

  if (PIPE_FILL < 1 || PIPE_FILL >= 2 ** (DEPTH - 1)) begin : g_bad_fill
    $error("ntt_ctrl_fsm: PIPE_FILL out of range");
  end

  state_e         state_q, state_d;
  logic [LYW-1:0] layer_q, layer_d;
  logic           mode_q, mode_d;
  logic           res_bank_q, res_bank_d;
  logic           rd_q, rd_d, wr_q, wr_d;
  logic [1:0]     ram_we_q, ram_we_d;
  logic           lt_q, lt_d;
  logic [LNW-1:0] len_q, len_d;
  logic           rok_q, rok_d, busy_q, busy_d, done_q, done_d;
  logic           t_load, t_expire, comp;
  logic [TW-1:0]  t_val;
  logic [LYW-1:0] last_layer;

  assign last_layer =
    LYW'(LAYERS) + LYW'(SCALE_EN && (mode_q == MODE_INTT));

  always_comb begin
    state_d    = state_q;
    layer_d    = layer_q;
    mode_d     = mode_q;
    res_bank_d = res_bank_q;
    t_load     = 1'b0;
    t_val      = '0;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_LOAD;
        mode_d     = mode;
        layer_d    = LYW'(1);
        res_bank_d = LAYERS_ODD ^ (SCALE_EN && (mode == MODE_INTT));
      end
      S_LOAD: if (full_in) state_d = S_WAIT_CAL;
      S_WAIT_CAL: if (cal_en) begin
        state_d = S_FILL;
        t_load  = 1'b1;
        t_val   = FILL_LD;
      end
      S_FILL: if (t_expire) begin
        state_d = S_RUN;
        t_load  = 1'b1;
        t_val   = RUN_LD;
      end
      S_RUN: if (t_expire) begin
        state_d = S_DRAIN;
        t_load  = 1'b1;
        t_val   = FILL_LD;
      end
      S_DRAIN: if (t_expire) state_d = S_GAP;
      S_GAP: if (layer_q == last_layer) begin
        state_d = S_OUT;
      end else begin
        state_d = S_FILL;
        layer_d = layer_q + LYW'(1);
        t_load  = 1'b1;
        t_val   = FILL_LD;
      end
      S_OUT: if (full_out) begin
        state_d = S_IDLE;
        layer_d = LYW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs are decoded from the next state so they register with it.
  always_comb begin
    comp  = state_d inside {S_FILL, S_RUN, S_DRAIN, S_GAP};
    rd_d  = state_d inside {S_FILL, S_RUN};
    wr_d  = state_d inside {S_RUN, S_DRAIN};
    lt_d  = comp && layer_d[0];
    rok_d = state_d inside {S_IDLE, S_LOAD};
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_OUT);
    ram_we_d = 2'b00;
    if (state_d == S_LOAD) ram_we_d = 2'b01;
    else if (wr_d) ram_we_d = layer_d[0] ? 2'b10 : 2'b01;
    len_d = '0;
    if (!comp || layer_d > LYW'(LAYERS)) len_d = '0;
    else if (mode_d == MODE_INTT) len_d = LNW'(layer_d);
    else len_d = LNW'(DEPTH) - LNW'(layer_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      layer_q    <= LYW'(1);
      mode_q     <= MODE_NTT;
      res_bank_q <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      ram_we_q   <= 2'b00;
      lt_q       <= 1'b0;
      len_q      <= '0;
      rok_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (set) begin
      state_q    <= state_d;
      layer_q    <= layer_d;
      mode_q     <= mode_d;
      res_bank_q <= res_bank_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      ram_we_q   <= ram_we_d;
      lt_q       <= lt_d;
      len_q      <= len_d;
      rok_q      <= rok_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  ctrl_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (set),
    .load     (t_load),
    .load_val (t_val),
    .expire   (t_expire)
  );

  assign rd_ctrl    = rd_q;
  assign wr_ctrl    = wr_q;
  assign ram_we     = ram_we_q;
  assign layer_type = lt_q;
  assign layer      = layer_q;
  assign len_log    = len_q;
  assign res_bank   = res_bank_q;
  assign readin_ok  = rok_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ntt_ctrl_fsm.sv
// Directed bench for ntt_ctrl_fsm: default instance plus a small
// DEPTH=4/PIPE_FILL=3/LAYERS=3 instance.
module tb_ntt_ctrl_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1, set = 1'b1, start = 1'b0, mode = 1'b0;
  logic full_in = 1'b0, cal_en = 1'b0, full_out = 1'b0;
  logic rd_ctrl, wr_ctrl, layer_type, res_bank, readin_ok, busy, done;
  logic [1:0] ram_we;
  logic [3:0] layer, len_log;

  logic s_set = 1'b1, s_start = 1'b0, s_mode = 1'b0;
  logic s_full_in = 1'b0, s_cal_en = 1'b0, s_full_out = 1'b0;
  logic s_rd, s_wr, s_lt, s_res_bank, s_rok, s_busy, s_done;
  logic [1:0] s_ram_we;
  logic [2:0] s_layer, s_len_log;

  int checks = 0;
  int errors = 0;
  int rd_per [10];
  int wr_per [10];
  int lens   [10];
  int bad_we;

  ntt_ctrl_fsm dut (
    .clk(clk), .reset(reset), .set(set), .start(start), .mode(mode),
    .full_in(full_in), .cal_en(cal_en), .full_out(full_out),
    .rd_ctrl(rd_ctrl), .wr_ctrl(wr_ctrl), .ram_we(ram_we),
    .layer_type(layer_type), .layer(layer), .len_log(len_log),
    .res_bank(res_bank), .readin_ok(readin_ok), .busy(busy), .done(done)
  );

  ntt_ctrl_fsm #(.DEPTH(4), .PIPE_FILL(3), .LAYERS(3)) u_small (
    .clk(clk), .reset(reset), .set(s_set), .start(s_start), .mode(s_mode),
    .full_in(s_full_in), .cal_en(s_cal_en), .full_out(s_full_out),
    .rd_ctrl(s_rd), .wr_ctrl(s_wr), .ram_we(s_ram_we),
    .layer_type(s_lt), .layer(s_layer), .len_log(s_len_log),
    .res_bank(s_res_bank), .readin_ok(s_rok), .busy(s_busy), .done(s_done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tally();
    int l;
    l = int'(layer);
    if (l > 9) l = 0;
    if (rd_ctrl) rd_per[l]++;
    if (wr_ctrl) begin
      wr_per[l]++;
      if (ram_we !== (layer[0] ? 2'b10 : 2'b01)) bad_we++;
      if (layer_type !== layer[0]) bad_we++;
    end
    if (!rd_ctrl && !wr_ctrl && busy && !done) lens[l] = int'(len_log);
  endtask

  // Entered just after the edge that moved WAIT_CAL to FILL.
  task automatic measure(input logic m, input int exp_cyc,
                         input int nl, input logic exp_bank,
                         input bit toggle);
    int n, guard, el;
    bit s, alt;
    for (int i = 0; i < 10; i++) begin
      rd_per[i] = 0; wr_per[i] = 0; lens[i] = -1;
    end
    bad_we = 0; n = 0; guard = 0; alt = 1'b0;
    tally();
    while (!done && guard < 6000) begin
      if (toggle) begin alt = ~alt; set = alt; end
      s = set;
      step();
      guard++;
      if (s) begin
        n++;
        if (!done) tally();
      end
    end
    set = 1'b1;
    chk("out_latency", n, exp_cyc);
    chk("done_at_out", done, 1'b1);
    chk("last_layer", layer, nl);
    chk("res_bank", res_bank, exp_bank);
    chk("ram_we_phase", bad_we, 0);
    for (int l = 1; l <= nl; l++) begin
      el = m ? ((l > 7) ? 0 : l) : (8 - l);
      chk($sformatf("rd_len_l%0d", l), rd_per[l], 128);
      chk($sformatf("wr_len_l%0d", l), wr_per[l], 128);
      chk($sformatf("len_log_l%0d", l), lens[l], el);
    end
  endtask

  task automatic unload();
    full_out = 1'b1; step(); full_out = 1'b0;
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_readin_ok", readin_ok, 1'b1);
  endtask

  initial begin
    int g, n, runrw, rdt;
    step(); step();
    reset = 1'b0;
    step();
    chk("rst_readin_ok", readin_ok, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ram_we", ram_we, 2'b00);
    chk("rst_layer", layer, 4'd1);
    chk("rst_len_log", len_log, 4'd0);
    chk("rst_res_bank", res_bank, 1'b0);
    chk("rst_rd_wr", {rd_ctrl, wr_ctrl, layer_type}, 3'b000);

    // NTT run, with a stray start pulse while busy
    mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    chk("load_busy", busy, 1'b1);
    chk("load_ram_we", ram_we, 2'b01);
    chk("load_readin_ok", readin_ok, 1'b1);
    full_in = 1'b1; step(); full_in = 1'b0;
    chk("wait_readin_ok", readin_ok, 1'b0);
    chk("wait_ram_we", ram_we, 2'b00);
    start = 1'b1; mode = 1'b1; step(); start = 1'b0; mode = 1'b0;
    chk("start_ignored", {busy, rd_ctrl, readin_ok}, 3'b100);
    cal_en = 1'b1; step(); cal_en = 1'b0;
    chk("fill_rd", {rd_ctrl, wr_ctrl}, 2'b10);
    measure(1'b0, 938, 7, 1'b1, 1'b0);
    unload();

    // INTT run with full_in and cal_en together in LOAD
    mode = 1'b1; start = 1'b1; step(); start = 1'b0; mode = 1'b0;
    full_in = 1'b1; cal_en = 1'b1; step(); full_in = 1'b0;
    chk("both_wait", {rd_ctrl, readin_ok, busy}, 3'b001);
    step(); cal_en = 1'b0;
    chk("both_fill", rd_ctrl, 1'b1);
`ifdef NTT_CTRL_SCALE_EN
    measure(1'b1, 1072, 8, 1'b0, 1'b0);
`else
    measure(1'b1, 938, 7, 1'b1, 1'b0);
`endif
    unload();

    // NTT run with set toggled every other cycle
    mode = 1'b0; start = 1'b1; step(); start = 1'b0;
    full_in = 1'b1; step(); full_in = 1'b0;
    cal_en = 1'b1; step(); cal_en = 1'b0;
    measure(1'b0, 938, 7, 1'b1, 1'b1);
    unload();

    // Reset during layer 4 DRAIN with set low
    start = 1'b1; step(); start = 1'b0;
    full_in = 1'b1; step(); full_in = 1'b0;
    cal_en = 1'b1; step(); cal_en = 1'b0;
    g = 0;
    while (!(layer == 4'd4 && wr_ctrl && !rd_ctrl) && g < 2000) begin
      step(); g++;
    end
    chk("reach_l4_drain", {layer, wr_ctrl, rd_ctrl}, {4'd4, 2'b10});
    reset = 1'b1; set = 1'b0; step();
    chk("mrst_readin_ok", readin_ok, 1'b1);
    chk("mrst_ram_we", ram_we, 2'b00);
    chk("mrst_layer", layer, 4'd1);
    chk("mrst_busy_wr", {busy, wr_ctrl}, 2'b00);
    reset = 1'b0; set = 1'b1; step();

    // Small configuration NTT run
    s_start = 1'b1; step(); s_start = 1'b0;
    s_full_in = 1'b1; step(); s_full_in = 1'b0;
    s_cal_en = 1'b1; step(); s_cal_en = 1'b0;
    n = 0; runrw = 0; rdt = 0;
    while (!s_done && n < 500) begin
      if (s_rd && s_wr) runrw++;
      if (s_rd) rdt++;
      step(); n++;
    end
    chk("small_latency", n, 36);
    chk("small_run_total", runrw, 15);
    chk("small_rd_total", rdt, 24);
    chk("small_res_bank", s_res_bank, 1'b1);
    s_full_out = 1'b1; step(); s_full_out = 1'b0;
    chk("small_idle", {s_busy, s_rok}, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_ctrl_fsm.md
# ntt_ctrl_fsm

- Layer-sequencing controller for the polynomial transform datapath, one FSM for both forward NTT and inverse NTT.
- Parametrised by transform size, butterfly pipeline latency and layer count; selects direction per run via `mode`.
- Drives read/write phase control, ping-pong RAM write enables and per-layer butterfly span to the address generators and butterfly unit.
- Sits between the host load/unload handshake and the two coefficient RAM banks.

## Interface
- `DEPTH`, 8: log2 of coefficient count; one layer is 2^(DEPTH-1) butterflies.
- `PIPE_FILL`, 5: cycles from butterfly read to write-back; must satisfy 1 ≤ PIPE_FILL < 2^(DEPTH-1), else elaboration error.
- `LAYERS`, 7: butterfly layers per transform.
- Ports:
  - `clk` in 1: the block's single clock.
  - `reset` in 1: synchronous, active-high reset.
  - `set` in 1: clock enable; when low, all state, counters and outputs hold.
  - `start` in 1: request a new run; accepted only in IDLE.
  - `mode` in 1: 0 = NTT, 1 = INTT; captured when `start` is accepted.
  - `full_in` in 1: input load complete.
  - `cal_en` in 1: permission to begin computing.
  - `full_out` in 1: output unload complete.
  - `rd_ctrl` out 1: butterfly read phase active.
  - `wr_ctrl` out 1: butterfly write phase active.
  - `ram_we` out 2: bit0 = bank0 WE, bit1 = bank1 WE.
  - `layer_type` out 1: 1 = odd layer (read bank0, write bank1).
  - `layer` out $clog2(LAYERS+2): current layer, 1-based.
  - `len_log` out $clog2(DEPTH+1): log2 of butterfly span for the current layer.
  - `res_bank` out 1: bank holding the final result.
  - `readin_ok` out 1: host may load.
  - `busy` out 1: high from `start` acceptance until OUT is exited.
  - `done` out 1: result valid for unload.

## Operation
- States: IDLE, LOAD, WAIT_CAL, FILL, RUN, DRAIN, GAP, OUT.
- Transitions:
  - IDLE→LOAD on `start`.
  - LOAD→WAIT_CAL on `full_in`.
  - WAIT_CAL→FILL on `cal_en`.
  - FILL lasts PIPE_FILL cycles, then RUN.
  - RUN lasts 2^(DEPTH-1)−PIPE_FILL cycles, then DRAIN.
  - DRAIN lasts PIPE_FILL cycles, then GAP.
  - GAP lasts 1 cycle; then OUT if `layer` == last layer, else FILL with `layer`+1.
  - OUT→IDLE on `full_out`.
- Phase outputs:
  - FILL: `rd_ctrl`=1, `wr_ctrl`=0.
  - RUN: `rd_ctrl`=1, `wr_ctrl`=1.
  - DRAIN: `rd_ctrl`=0, `wr_ctrl`=1.
  - GAP: `rd_ctrl`=0, `wr_ctrl`=0.
- Write enables:
  - In RUN and DRAIN, `ram_we` = 2'b10 on odd layers and 2'b01 on even layers.
  - In LOAD, `ram_we` = 2'b01.
  - Otherwise `ram_we` = 2'b00.
- `len_log`:
  - NTT: DEPTH−`layer`.
  - INTT: `layer`.
- Status outputs:
  - `readin_ok` = 1 in IDLE and LOAD only.
  - `done` = 1 in OUT only.
- `res_bank` = parity of the total layer count, constant during a run.
- `start` outside IDLE is ignored.
- `cal_en` is sampled only in WAIT_CAL.
- `full_in` is sampled only in LOAD.
- `full_out` is sampled only in OUT.
- Simultaneous `full_in` and `cal_en` in LOAD: go to WAIT_CAL only; `cal_en` takes effect from the next cycle.

## Timing
- All outputs are registered Moore outputs and update on the same `set`-qualified edge as the state register.
- `set` low freezes the FSM; a phase spans exactly its stated number of `set`-high cycles.
- Reset values: state IDLE, `layer`=1, timers 0, `readin_ok`=1, every other output 0 (`ram_we`=2'b00).
- Reset mid-run: IDLE and reset values on the next edge, regardless of `set`.
- Layer period = 2^DEPTH−? is not used; layer period = 2^(DEPTH-1)+PIPE_FILL+1 cycles.
- Reads and writes per layer are exactly 2^(DEPTH-1) cycles each.
- Compute latency from WAIT_CAL exit to OUT entry = total layers × layer period.

## Configuration
- Macro: `NTT_CTRL_SCALE_EN`.
- With the macro defined and `mode`=1, one extra layer (LAYERS+1) runs after the last butterfly layer to multiply by n⁻¹:
  - Same FILL/RUN/DRAIN/GAP timing as a butterfly layer.
  - `len_log`=0.
  - `res_bank` reflects LAYERS+1.
- Without the macro, or with `mode`=0, exactly LAYERS layers run.

## Structure
- `ntt_ctrl_pkg` holds the state enum (one-hot), mode constants (`MODE_NTT`, `MODE_INTT`) and the layer-period helper function.
- Sub-module `ctrl_phase_timer`:
  - Loadable down-counter.
  - Asserts `expire` in the last cycle of a phase.
  - Width $clog2(2^(DEPTH-1)).

## Test plan
All scenarios use defaults (DEPTH=8, PIPE_FILL=5, LAYERS=7) unless noted.
- NTT run: `start`, `full_in`, `cal_en`, `mode`=0 → per layer `rd_ctrl` high 128 cycles and `wr_ctrl` high 128 cycles; `len_log` steps 7..1; OUT entered 938 cycles after WAIT_CAL exit; `res_bank`=1.
- INTT with `NTT_CTRL_SCALE_EN` defined → `len_log` steps 1..7 then 0; OUT after 1072 cycles; `res_bank`=0.
- `set` toggled 50% during RUN → phase lengths counted in `set`-high cycles only; totals unchanged.
- `reset` asserted in layer 4 DRAIN → next cycle: IDLE, `ram_we`=0, `readin_ok`=1, `layer`=1.
- `full_in` and `cal_en` asserted together in LOAD → WAIT_CAL, then FILL one cycle later; `start` pulsed while `busy` → ignored.
- DEPTH=4, PIPE_FILL=3, LAYERS=3 → RUN lasts 5 cycles; layer period 12; OUT after 36 cycles.
